// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with single-cycle grant.
// A winner in weighted mode holds the grant for a credit-limited burst.
module weighted_rr_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned WEIGHT_W = 4
) (
   input  logic                          clk_i,
   input  logic                          arst_ni,
   input  logic                          allow_i,
   input  logic                          mode_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*WEIGHT_W-1:0]   weight_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic                          gnt_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_idx_o,
   output logic                          burst_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   typedef enum logic {
      ARB,
      BURST
   } state_e;

   state_e               state_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        owner_q;
   logic [WEIGHT_W-1:0]  credit_q;

   logic [IW-1:0]        owner_nxt;
   logic [IW-1:0]        start;
   logic [IW-1:0]        cand;
   logic [IW-1:0]        win;
   logic                 found;
   logic                 hold;
   logic [WEIGHT_W-1:0]  w_sel;
   logic [WEIGHT_W-1:0]  w_eff;
   logic                 valid;
   logic [IW-1:0]        idx;

   function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
      if (i == IW'(NUM_REQ - 1)) return '0;
      return i + IW'(1);
   endfunction

   // Circular search for the first requester, starting at ptr or past the owner
   always_comb begin
      owner_nxt = inc_idx(owner_q);
      hold      = (state_q == BURST) && req_i[owner_q];
      start     = (state_q == BURST) ? owner_nxt : ptr_q;
      found     = 1'b0;
      win       = '0;
      cand      = start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
         cand = inc_idx(cand);
      end
      w_sel = weight_i[int'(win)*int'(WEIGHT_W) +: WEIGHT_W];
      w_eff = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;
   end

   // Grant outputs; suppressed while reset is asserted
   always_comb begin
      valid       = allow_i && arst_ni && (hold || found);
      idx         = hold ? owner_q : win;
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = valid;
      if (valid) begin
         gnt_o[idx] = 1'b1;
         gnt_idx_o  = idx;
      end
      burst_o = (state_q == BURST);
   end

   // Arbitration FSM: pointer rotation, burst ownership and credit
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q  <= ARB;
         ptr_q    <= '0;
         owner_q  <= '0;
         credit_q <= '0;
      end else if (allow_i) begin
         if (hold) begin
            credit_q <= credit_q - WEIGHT_W'(1);
            if (credit_q == WEIGHT_W'(1)) begin
               state_q <= ARB;
               ptr_q   <= owner_nxt;
            end
         end else if (found) begin
            if (mode_i && (w_eff > WEIGHT_W'(1))) begin
               state_q  <= BURST;
               owner_q  <= win;
               credit_q <= w_eff - WEIGHT_W'(1);
               ptr_q    <= start;
            end else begin
               state_q  <= ARB;
               ptr_q    <= inc_idx(win);
               credit_q <= '0;
            end
         end else if (state_q == BURST) begin
            state_q  <= ARB;
            ptr_q    <= owner_nxt;
            credit_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench for weighted_rr_arbiter.
// Directed vectors carry hand-computed results; a random phase uses a model.
module tb_weighted_rr_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic             clk = 1'b0;
   logic             arst_ni;
   logic             allow;
   logic             mode;
   logic [N-1:0]     req;
   logic [N*W-1:0]   weight;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [1:0]       gnt_idx;
   logic             burst;

   typedef struct packed {
      logic       v;
      logic [1:0] idx;
      logic       b;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;

   exp_t         mon_e;
   logic [N-1:0] mon_g;

   int m_ptr, m_owner, m_credit;
   bit m_burst;

   weighted_rr_arbiter #(.NUM_REQ(N), .WEIGHT_W(W)) dut (
      .clk_i       (clk),
      .arst_ni     (arst_ni),
      .allow_i     (allow),
      .mode_i      (mode),
      .req_i       (req),
      .weight_i    (weight),
      .gnt_o       (gnt),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx),
      .burst_o     (burst)
   );

   always #5 clk = ~clk;

   // Monitor: compare DUT outputs with the oldest expectation each cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         mon_g = mon_e.v ? (N'(1) << mon_e.idx) : '0;
         checks++;
         if ({gnt, gnt_valid, gnt_idx, burst} ===
             {mon_g, mon_e.v, mon_e.idx, mon_e.b})
            passed++;
         else
            $display("FAIL grant t=%0t got gnt=%b v=%b idx=%0d burst=%b need gnt=%b v=%b idx=%0d burst=%b",
                     $time, gnt, gnt_valid, gnt_idx, burst,
                     mon_g, mon_e.v, mon_e.idx, mon_e.b);
         checks++;
         if ($onehot0(gnt) && ((gnt & ~(req & {N{allow}})) == '0))
            passed++;
         else
            $display("FAIL invariant t=%0t got gnt=%b req=%b allow=%b need onehot0 subset",
                     $time, gnt, req, allow);
      end
   end

   task automatic drive(input logic rst, input logic al, input logic md,
                        input logic [N-1:0] rq, input logic [N*W-1:0] wt);
      @(posedge clk);
      #1;
      arst_ni = rst;
      allow   = al;
      mode    = md;
      req     = rq;
      weight  = wt;
   endtask

   task automatic vec(input logic rst, input logic al, input logic md,
                      input logic [N-1:0] rq, input logic [N*W-1:0] wt,
                      input logic ev, input int ei, input logic eb);
      exp_t e;
      drive(rst, al, md, rq, wt);
      e.v   = ev;
      e.idx = ei[1:0];
      e.b   = eb;
      q.push_back(e);
   endtask

   task automatic do_reset();
      vec(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0);
      vec(1'b0, 1'b1, 1'b1, 4'hF, '0, 1'b0, 0, 1'b0);
      m_ptr    = 0;
      m_owner  = 0;
      m_credit = 0;
      m_burst  = 0;
   endtask

   task automatic model_step(input logic al, input logic md,
                             input logic [N-1:0] rq, input logic [N*W-1:0] wt,
                             output exp_t e);
      e   = '0;
      e.b = m_burst;
      if (!al) return;
      if (m_burst && rq[m_owner]) begin
         e.v   = 1'b1;
         e.idx = 2'(m_owner);
         m_credit--;
         if (m_credit == 0) begin
            m_burst = 0;
            m_ptr   = (m_owner + 1) % N;
         end
         return;
      end
      if (m_burst) begin
         m_burst = 0;
         m_ptr   = (m_owner + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
         int j;
         int w;
         j = (m_ptr + k) % N;
         if (rq[j]) begin
            w = int'(wt[j*W +: W]);
            if (w == 0) w = 1;
            e.v   = 1'b1;
            e.idx = 2'(j);
            if (md && w > 1) begin
               m_burst  = 1;
               m_owner  = j;
               m_credit = w - 1;
            end else begin
               m_ptr = (j + 1) % N;
            end
            return;
         end
      end
   endtask

   initial begin
      int s2_idx[8];
      int s2_b[8];
      logic [N*W-1:0] wts;
      exp_t e;
      logic al, md;
      logic [N-1:0] rq;

      arst_ni = 1'b0;
      allow   = 1'b0;
      mode    = 1'b0;
      req     = '0;
      weight  = '0;

      // plain round-robin
      do_reset();
      for (int i = 0; i < 8; i++)
         vec(1'b1, 1'b1, 1'b0, 4'hF, '0, 1'b1, i % 4, 1'b0);

      // weighted {3,1,2,1}
      do_reset();
      s2_idx = '{0, 0, 0, 1, 2, 2, 3, 0};
      s2_b   = '{0, 1, 1, 0, 0, 1, 0, 0};
      wts    = {4'd1, 4'd2, 4'd1, 4'd3};
      for (int i = 0; i < 8; i++)
         vec(1'b1, 1'b1, 1'b1, 4'hF, wts, 1'b1, s2_idx[i], s2_b[i][0]);

      // allow pauses inside a burst of 4
      do_reset();
      vec(1'b1, 1'b1, 1'b1, 4'b0001, 16'h0004, 1'b1, 0, 1'b0);
      vec(1'b1, 1'b0, 1'b1, 4'b0001, 16'h0004, 1'b0, 0, 1'b1);
      vec(1'b1, 1'b0, 1'b1, 4'b0001, 16'h0004, 1'b0, 0, 1'b1);
      vec(1'b1, 1'b1, 1'b1, 4'b0001, 16'h0004, 1'b1, 0, 1'b1);
      vec(1'b1, 1'b1, 1'b1, 4'b0001, 16'h0004, 1'b1, 0, 1'b1);
      vec(1'b1, 1'b1, 1'b1, 4'b0001, 16'h0004, 1'b1, 0, 1'b1);
      vec(1'b1, 1'b1, 1'b0, 4'hF,    16'h0004, 1'b1, 1, 1'b0);

      // owner drops request: no bubble
      do_reset();
      vec(1'b1, 1'b1, 1'b1, 4'b1011, 16'h0013, 1'b1, 0, 1'b0);
      vec(1'b1, 1'b1, 1'b1, 4'b1010, 16'h0013, 1'b1, 1, 1'b1);
      vec(1'b1, 1'b1, 1'b0, 4'b1011, 16'h0013, 1'b1, 3, 1'b0);

      // zero weights behave as plain round-robin
      do_reset();
      for (int i = 0; i < 8; i++)
         vec(1'b1, 1'b1, 1'b1, 4'hF, '0, 1'b1, i % 4, 1'b0);

      // reset during a burst
      do_reset();
      vec(1'b1, 1'b1, 1'b1, 4'b0100, 16'h0500, 1'b1, 2, 1'b0);
      vec(1'b0, 1'b1, 1'b1, 4'b0100, 16'h0500, 1'b0, 0, 1'b0);
      vec(1'b1, 1'b1, 1'b1, 4'hF,    16'h0500, 1'b1, 0, 1'b0);
      vec(1'b1, 1'b1, 1'b1, 4'hF,    16'h0500, 1'b1, 1, 1'b0);

      // random traffic against the model
      do_reset();
      wts = '0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0)
            for (int k = 0; k < N; k++)
               wts[k*W +: W] = W'($urandom_range(0, 5));
         al = ($urandom_range(0, 7) != 0);
         md = ($urandom_range(0, 3) != 0);
         rq = N'($urandom);
         drive(1'b1, al, md, rq, wts);
         model_step(al, md, rq, wts, e);
         q.push_back(e);
      end

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain got %0d pending need 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
